// File: rtl/id_ex_hazard_stage_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID/EX stage of the non-forwarding pipeline:
// ALU op class encodings, the default register-address width and the packed
// control bundle carried from ID into EX.
// -----------------------------------------------------------------------------
package pipe_pkg;

   localparam int REG_AW = 5;

   localparam logic [1:0] ALUOP_ADD = 2'b00;
   localparam logic [1:0] ALUOP_RI  = 2'b01;
   localparam logic [1:0] ALUOP_BR  = 2'b10;

   // Control fields latched by the ID/EX register (rd is kept separately so
   // its width can follow the module parameter).
   typedef struct packed {
      logic       valid;
      logic [2:0] funct3;
      logic       funct7b5;
      logic [1:0] alu_op;
      logic       opcode_b5;
      logic       reg_wr;
   } id_ex_ctrl_t;

   // All-zero control word; alu_op=ADD with no writeback is a harmless bubble.
   function automatic id_ex_ctrl_t bubble_ctrl();
      id_ex_ctrl_t c;
      c.valid     = 1'b0;
      c.funct3    = 3'b000;
      c.funct7b5  = 1'b0;
      c.alu_op    = ALUOP_ADD;
      c.opcode_b5 = 1'b0;
      c.reg_wr    = 1'b0;
      return c;
   endfunction

endpackage

// File: rtl/id_ex_hazard_stage_if.sv
// -----------------------------------------------------------------------------
// id_ex_if
// ID-side inputs, EX-side outputs and the IF/ID stall of the ID/EX stage.
//   master : upstream/downstream pipeline (drives id_*, ex_flush, pipe_hold)
//   slave  : id_ex_hazard_stage (drives ex_*, stall_ifid)
// -----------------------------------------------------------------------------
interface id_ex_if #(
   parameter int REG_AW = pipe_pkg::REG_AW
);
   logic              id_valid;
   logic [2:0]        id_funct3;
   logic              id_funct7b5;
   logic [1:0]        id_alu_op;
   logic              id_opcode_b5;
   logic [REG_AW-1:0] id_rs1;
   logic [REG_AW-1:0] id_rs2;
   logic              id_rs1_used;
   logic              id_rs2_used;
   logic [REG_AW-1:0] id_rd;
   logic              id_reg_wr;
   logic              ex_flush;
   logic              pipe_hold;

   logic              ex_valid;
   logic [2:0]        ex_funct3;
   logic              ex_funct7b5;
   logic [1:0]        ex_alu_op;
   logic              ex_opcode_b5;
   logic [REG_AW-1:0] ex_rd;
   logic              ex_reg_wr;
   logic              stall_ifid;

   modport master (
      output id_valid, id_funct3, id_funct7b5, id_alu_op, id_opcode_b5,
             id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_wr,
             ex_flush, pipe_hold,
      input  ex_valid, ex_funct3, ex_funct7b5, ex_alu_op, ex_opcode_b5,
             ex_rd, ex_reg_wr, stall_ifid
   );

   modport slave (
      input  id_valid, id_funct3, id_funct7b5, id_alu_op, id_opcode_b5,
             id_rs1, id_rs2, id_rs1_used, id_rs2_used, id_rd, id_reg_wr,
             ex_flush, pipe_hold,
      output ex_valid, ex_funct3, ex_funct7b5, ex_alu_op, ex_opcode_b5,
             ex_rd, ex_reg_wr, stall_ifid
   );
endinterface

// File: rtl/id_ex_hazard_stage_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
// Shift array of in-flight writers {wr, rd}; entry 0 mirrors the EX register,
// older entries track MEM/WB. Flags a RAW hazard when a used, nonzero source
// register of the ID instruction matches any recorded writer.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   shift_en            advance the array by one stage this edge
//   push_wr, push_rd    new entry 0 contents
//   id_valid            ID holds a real instruction
//   rs1/rs2, *_used     ID source registers and their use flags
//   hazard              combinational RAW hazard flag
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
   parameter int HAZ_DEPTH = 3,
   parameter int REG_AW    = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic              push_wr,
   input  logic [REG_AW-1:0] push_rd,
   input  logic              id_valid,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              rs1_used,
   input  logic              rs2_used,
   output logic              hazard
);
   logic              wr_r [HAZ_DEPTH];
   logic [REG_AW-1:0] rd_r [HAZ_DEPTH];
   logic              match1_s;
   logic              match2_s;

   // Writer shift array: new entry at 0, oldest falls off the end.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            wr_r[i] <= 1'b0;
            rd_r[i] <= {REG_AW{1'b0}};
         end
      end else if (shift_en) begin
         wr_r[0] <= push_wr;
         rd_r[0] <= push_rd;
         for (int i = 1; i < HAZ_DEPTH; i++) begin
            wr_r[i] <= wr_r[i-1];
            rd_r[i] <= rd_r[i-1];
         end
      end else begin
         for (int i = 0; i < HAZ_DEPTH; i++) begin
            wr_r[i] <= wr_r[i];
            rd_r[i] <= rd_r[i];
         end
      end
   end

   // Compare both sources against every live writer entry.
   always_comb begin
      match1_s = 1'b0;
      match2_s = 1'b0;
      for (int i = 0; i < HAZ_DEPTH; i++) begin
         match1_s = match1_s | (wr_r[i] && (rd_r[i] == rs1));
         match2_s = match2_s | (wr_r[i] && (rd_r[i] == rs2));
      end
   end

   // x0 is hardwired, so a read of x0 never waits.
   assign hazard = id_valid &&
                   ((rs1_used && (rs1 != {REG_AW{1'b0}}) && match1_s) ||
                    (rs2_used && (rs2 != {REG_AW{1'b0}}) && match2_s));

endmodule

// File: rtl/id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// id_ex_hazard_stage
// ID/EX pipeline register with RAW interlock for the non-forwarding pipeline.
// Latches decoded ALU-control fields, and while a source register still has a
// write in flight it stalls IF/ID and injects bubbles into EX.
// Ports:
//   clk        clock
//   rst_n      synchronous active-low reset
//   bus        id_ex_if.slave: id_* decoded fields, ex_flush, pipe_hold in;
//              ex_* ALU-control/writeback fields and stall_ifid out
//   stall_cnt  (only with ID_EX_STALL_CNT_EN) count of hazard bubbles
// Optional build macro: ID_EX_STALL_CNT_EN adds the stall_cnt counter/port.
// Edge priority: pipe_hold > ex_flush > hazard > normal load.
// -----------------------------------------------------------------------------
module id_ex_hazard_stage #(
   parameter int HAZ_DEPTH = 3,
   parameter int REG_AW    = pipe_pkg::REG_AW
) (
   input  logic        clk,
   input  logic        rst_n,
   id_ex_if.slave      bus
`ifdef ID_EX_STALL_CNT_EN
   ,
   output logic [31:0] stall_cnt
`endif
);
   import pipe_pkg::*;

   id_ex_ctrl_t       ex_ctrl_r;
   logic [REG_AW-1:0] ex_rd_r;
   id_ex_ctrl_t       id_ctrl_s;
   logic              hazard_s;
   logic              shift_s;
   logic              load_s;
   logic              stall_s;
   logic              push_wr_s;
   logic [REG_AW-1:0] push_rd_s;

   hazard_scoreboard #(
      .HAZ_DEPTH (HAZ_DEPTH),
      .REG_AW    (REG_AW)
   ) u_scoreboard (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (shift_s),
      .push_wr  (push_wr_s),
      .push_rd  (push_rd_s),
      .id_valid (bus.id_valid),
      .rs1      (bus.id_rs1),
      .rs2      (bus.id_rs2),
      .rs1_used (bus.id_rs1_used),
      .rs2_used (bus.id_rs2_used),
      .hazard   (hazard_s)
   );

   // Control fields presented by ID.
   always_comb begin
      id_ctrl_s.valid     = bus.id_valid;
      id_ctrl_s.funct3    = bus.id_funct3;
      id_ctrl_s.funct7b5  = bus.id_funct7b5;
      id_ctrl_s.alu_op    = bus.id_alu_op;
      id_ctrl_s.opcode_b5 = bus.id_opcode_b5;
      id_ctrl_s.reg_wr    = bus.id_reg_wr;
   end

   // Decide hold / bubble / load; a flush cancels the stall since the ID
   // instruction is being discarded anyway.
   always_comb begin
      shift_s = 1'b0;
      load_s  = 1'b0;
      stall_s = 1'b0;
      if (bus.pipe_hold) begin
         stall_s = 1'b1;
      end else if (bus.ex_flush) begin
         shift_s = 1'b1;
      end else if (hazard_s) begin
         shift_s = 1'b1;
         stall_s = 1'b1;
      end else begin
         shift_s = 1'b1;
         load_s  = 1'b1;
      end
   end

   // New scoreboard entry: only real writers to a nonzero rd are recorded.
   always_comb begin
      push_wr_s = load_s && bus.id_valid && bus.id_reg_wr &&
                  (bus.id_rd != {REG_AW{1'b0}});
      if (load_s) begin
         push_rd_s = bus.id_rd;
      end else begin
         push_rd_s = {REG_AW{1'b0}};
      end
   end

   // ID/EX register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ex_ctrl_r <= bubble_ctrl();
         ex_rd_r   <= {REG_AW{1'b0}};
      end else if (bus.pipe_hold) begin
         ex_ctrl_r <= ex_ctrl_r;
         ex_rd_r   <= ex_rd_r;
      end else if (load_s) begin
         ex_ctrl_r <= id_ctrl_s;
         ex_rd_r   <= bus.id_rd;
      end else begin
         ex_ctrl_r <= bubble_ctrl();
         ex_rd_r   <= {REG_AW{1'b0}};
      end
   end

   assign bus.ex_valid     = ex_ctrl_r.valid;
   assign bus.ex_funct3    = ex_ctrl_r.funct3;
   assign bus.ex_funct7b5  = ex_ctrl_r.funct7b5;
   assign bus.ex_alu_op    = ex_ctrl_r.alu_op;
   assign bus.ex_opcode_b5 = ex_ctrl_r.opcode_b5;
   assign bus.ex_reg_wr    = ex_ctrl_r.reg_wr;
   assign bus.ex_rd        = ex_rd_r;
   assign bus.stall_ifid   = stall_s;

`ifdef ID_EX_STALL_CNT_EN
   logic        haz_bubble_s;
   logic [31:0] stall_cnt_r;

   assign haz_bubble_s = !bus.pipe_hold && !bus.ex_flush && hazard_s;

   // Count hazard bubbles only (not flush bubbles or held cycles); wraps.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stall_cnt_r <= 32'd0;
      end else if (haz_bubble_s) begin
         stall_cnt_r <= stall_cnt_r + 32'd1;
      end else begin
         stall_cnt_r <= stall_cnt_r;
      end
   end

   assign stall_cnt = stall_cnt_r;
`endif

endmodule

// File: tb/tb_id_ex_hazard_stage.sv
// -----------------------------------------------------------------------------
// tb_id_ex_hazard_stage
// Directed bench: each row gives one cycle's inputs plus the hand-derived
// stall_ifid for that cycle and the EX contents visible during it. Rows are
// queued by the driver; a monitor pops one per cycle on the falling edge.
// -----------------------------------------------------------------------------
module tb_id_ex_hazard_stage;

   typedef struct packed {
      logic       v;
      logic [2:0] f3;
      logic       f7;
      logic [1:0] op;
      logic       ob5;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       wr;
   } instr_t;

   typedef struct packed {
      logic       v;
      logic [2:0] f3;
      logic       f7;
      logic [1:0] op;
      logic       ob5;
      logic [4:0] rd;
      logic       wr;
   } ex_t;

   typedef struct {
      int          idx;
      logic        chk;
      logic        stall;
      ex_t         ex;
      logic        chk_cnt;
      logic [31:0] cnt;
   } exp_t;

   //                                  v     f3    f7    op     ob5   rs1    rs2    u1    u2    rd     wr
   localparam instr_t BUB    = '{1'b0, 3'd0, 1'b0, 2'b00, 1'b0, 5'd0,  5'd0,  1'b0, 1'b0, 5'd0,  1'b0};
   localparam instr_t ADD123 = '{1'b1, 3'd0, 1'b0, 2'b01, 1'b1, 5'd2,  5'd3,  1'b1, 1'b1, 5'd1,  1'b1};
   localparam instr_t SUB456 = '{1'b1, 3'd0, 1'b1, 2'b01, 1'b1, 5'd5,  5'd6,  1'b1, 1'b1, 5'd4,  1'b1};
   localparam instr_t ADD712 = '{1'b1, 3'd0, 1'b0, 2'b01, 1'b1, 5'd1,  5'd2,  1'b1, 1'b1, 5'd7,  1'b1};
   localparam instr_t ADDI0  = '{1'b1, 3'd0, 1'b0, 2'b01, 1'b0, 5'd0,  5'd0,  1'b1, 1'b0, 5'd0,  1'b1};
   localparam instr_t RD0    = '{1'b1, 3'd7, 1'b0, 2'b01, 1'b1, 5'd0,  5'd0,  1'b1, 1'b1, 5'd8,  1'b1};

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;
   int   cyc;
   exp_t exp_q[$];

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   id_ex_if #(.REG_AW(5)) bus ();

   id_ex_hazard_stage #(
      .HAZ_DEPTH (3),
      .REG_AW    (5)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus)
`ifdef ID_EX_STALL_CNT_EN
      ,
      .stall_cnt (stall_cnt)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic ex_t proj(input instr_t i);
      return {i.v, i.f3, i.f7, i.op, i.ob5, i.rd, i.wr};
   endfunction

   task automatic row(input logic rst, input instr_t in, input logic fl,
                      input logic hd, input logic chk, input logic est,
                      input instr_t eex, input logic ccnt = 1'b0,
                      input logic [31:0] ecnt = 32'd0);
      exp_t e;
      rst_n            = rst;
      bus.id_valid     = in.v;
      bus.id_funct3    = in.f3;
      bus.id_funct7b5  = in.f7;
      bus.id_alu_op    = in.op;
      bus.id_opcode_b5 = in.ob5;
      bus.id_rs1       = in.rs1;
      bus.id_rs2       = in.rs2;
      bus.id_rs1_used  = in.u1;
      bus.id_rs2_used  = in.u2;
      bus.id_rd        = in.rd;
      bus.id_reg_wr    = in.wr;
      bus.ex_flush     = fl;
      bus.pipe_hold    = hd;
      e.idx     = cyc;
      e.chk     = chk;
      e.stall   = est;
      e.ex      = proj(eex);
      e.chk_cnt = ccnt;
      e.cnt     = ecnt;
      exp_q.push_back(e);
      cyc++;
      @(posedge clk);
      #2;
   endtask

   // Monitor: one expectation per cycle, sampled on the falling edge.
   initial begin
      exp_t e;
      ex_t  act;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e.chk) begin
               n_tests++;
               if (bus.stall_ifid !== e.stall) begin
                  n_fail++;
                  $display("FAIL stall_ifid row %0d: got %b expected %b", e.idx, bus.stall_ifid, e.stall);
               end
               act = {bus.ex_valid, bus.ex_funct3, bus.ex_funct7b5, bus.ex_alu_op,
                      bus.ex_opcode_b5, bus.ex_rd, bus.ex_reg_wr};
               n_tests++;
               if (act !== e.ex) begin
                  n_fail++;
                  $display("FAIL ex_fields row %0d: got %h expected %h", e.idx, act, e.ex);
               end
            end
`ifdef ID_EX_STALL_CNT_EN
            if (e.chk_cnt) begin
               n_tests++;
               if (stall_cnt !== e.cnt) begin
                  n_fail++;
                  $display("FAIL stall_cnt row %0d: got %0d expected %0d", e.idx, stall_cnt, e.cnt);
               end
            end
`endif
         end
      end
   end

   initial begin
      n_tests = 0;
      n_fail  = 0;
      cyc     = 0;
      rst_n   = 1'b0;
      bus.id_valid = 1'b0; bus.id_funct3 = 3'd0; bus.id_funct7b5 = 1'b0;
      bus.id_alu_op = 2'b00; bus.id_opcode_b5 = 1'b0; bus.id_rs1 = 5'd0;
      bus.id_rs2 = 5'd0; bus.id_rs1_used = 1'b0; bus.id_rs2_used = 1'b0;
      bus.id_rd = 5'd0; bus.id_reg_wr = 1'b0; bus.ex_flush = 1'b0;
      bus.pipe_hold = 1'b0;
      @(posedge clk);
      #2;
      // Reset for two cycles with a valid instruction in ID.
      row(1'b0, ADD123, 1'b0, 1'b0, 1'b0, 1'b0, BUB);
      row(1'b0, ADD123, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      // Independent stream, then a dependent on x1 two back (2 bubbles).
      row(1'b1, ADD123, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, SUB456, 1'b0, 1'b0, 1'b1, 1'b0, ADD123);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, SUB456);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, BUB,    1'b0, 1'b0, 1'b1, 1'b0, ADD712);
      // Back-to-back RAW: 3 bubbles, issue on the 4th cycle.
      row(1'b1, ADD123, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, ADD123);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, BUB,    1'b0, 1'b0, 1'b1, 1'b0, ADD712, 1'b1, 32'd5);
      // x0 destination then x0 reader: no stall.
      row(1'b1, ADDI0,  1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, RD0,    1'b0, 1'b0, 1'b1, 1'b0, ADDI0);
      row(1'b1, BUB,    1'b0, 1'b0, 1'b1, 1'b0, RD0);
      // Flush on the 2nd stall cycle: no stall that cycle, scoreboard drains.
      row(1'b1, ADD123, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, ADD123);
      row(1'b1, ADD712, 1'b1, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, BUB,    1'b0, 1'b0, 1'b1, 1'b0, ADD712);
      // Hold 4 cycles mid-hazard: everything frozen, then 3 bubbles remain.
      row(1'b1, ADD123, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      for (int i = 0; i < 4; i++) begin
         row(1'b1, ADD712, 1'b0, 1'b1, 1'b1, 1'b1, ADD123);
      end
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, ADD123);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, BUB,    1'b0, 1'b0, 1'b1, 1'b0, ADD712);
      // Reset asserted mid-stall clears stall and scoreboard on that edge.
      row(1'b1, ADD123, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, ADD123);
      row(1'b0, ADD712, 1'b0, 1'b0, 1'b1, 1'b1, BUB, 1'b1, 32'd11);
      row(1'b1, ADD712, 1'b0, 1'b0, 1'b1, 1'b0, BUB);
      row(1'b1, BUB,    1'b0, 1'b0, 1'b1, 1'b0, ADD712, 1'b1, 32'd0);
      row(1'b1, BUB,    1'b0, 1'b0, 1'b1, 1'b0, BUB);
      repeat (2) @(negedge clk);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/id_ex_hazard_stage.md
Name: id_ex_hazard_stage

Overview:
- ID/EX pipeline register for the non-forwarding pipeline.
- Adds a RAW interlock: it latches decoded control/operand fields, stalls IF/ID and injects bubbles while a source register has a write still in flight.
- Its EX-side outputs drive the ALU-control decoder directly: funct3, funct7 bit 5, ALU op and opcode bit 5.

Parameters:
- HAZ_DEPTH, 3: in-flight writer stages tracked (EX, MEM, WB). Use 2 when the register file writes before it reads.
- REG_AW, 5: register-address width.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk
- id_valid  in  1  ID holds a real instruction
- id_funct3  in  3  instruction funct3
- id_funct7b5  in  1  bit 5 of funct7
- id_alu_op  in  2  ALU op class from the main decoder
- id_opcode_b5  in  1  opcode bit 5 (R vs I)
- id_rs1, id_rs2  in  REG_AW  source registers
- id_rs1_used, id_rs2_used  in  1  source actually read
- id_rd  in  REG_AW  destination register
- id_reg_wr  in  1  instruction writes rd
- ex_flush  in  1  branch/jump redirect resolved in EX
- pipe_hold  in  1  global freeze (e.g. memory wait)
- ex_valid  out  1  EX holds a real instruction
- ex_funct3  out  3  to ALU control
- ex_funct7b5  out  1  to ALU control
- ex_alu_op  out  2  to ALU control
- ex_opcode_b5  out  1  to ALU control
- ex_rd  out  REG_AW  destination register in EX
- ex_reg_wr  out  1  EX instruction writes rd
- stall_ifid  out  1  hold PC and IF/ID register this cycle

Behaviour:
- Reset (rst_n=0 at a clk edge): all ex_* outputs = 0, all scoreboard entries invalid. stall_ifid is combinational, so it reads 0 while the scoreboard is empty.
- Scoreboard: HAZ_DEPTH entries {wr, rd}. Entry 0 mirrors the EX register; each non-held cycle entry[i] moves to entry[i+1] and the oldest entry is dropped.
- Hazard (combinational) = id_valid && (src1 or src2 match), where:
  - a source matches when it is used, is nonzero, and equals any entry with wr=1;
  - rd=x0 is never recorded as a writer.
- Priority on each clk edge, highest first:
  1. pipe_hold=1: every register keeps its value; stall_ifid=1.
  2. ex_flush=1: EX loads a bubble; scoreboard shifts; stall_ifid=0. The wrong-path ID instruction is discarded upstream.
  3. Hazard=1: EX loads a bubble; scoreboard shifts; stall_ifid=1.
  4. Otherwise: EX loads the id_* fields with ex_valid=id_valid; entry 0 = {id_valid&&id_reg_wr&&id_rd!=0, id_rd}.
- Bubble contents: all ex_* fields 0. ex_alu_op=00 decodes to ADD with no writeback, which is harmless.
- Latency: id_* to ex_* is exactly one cycle when no stall.
- Dependent back-to-back instruction with HAZ_DEPTH=3: 3 bubbles, then it issues on the 4th cycle.
- Reset asserted mid-stall: bubbles and the stall clear on that same edge.

Optional Feature:
- Macro: ID_EX_STALL_CNT_EN.
- When defined:
  - adds output stall_cnt [31:0];
  - increments on every edge where a hazard bubble is inserted (case 3 only), wrapping at 2^32;
  - is cleared by reset.
- When undefined: no port and no counter logic.

Decomposition:
- Shared package pipe_pkg holds:
  - ALU_OP constants: ALUOP_ADD=2'b00, ALUOP_RI=2'b01, ALUOP_BR=2'b10;
  - REG_AW;
  - the typedef for an id_ex control struct.
- One sub-module, hazard_scoreboard: the shift array and match logic, outputting a hazard flag.

Test Plan:
- Reset: rst_n=0 for 2 cycles with id_valid=1 → all ex_*=0, stall_ifid=0.
- Independent stream: add x1,x2,x3 then sub x4,x5,x6 (funct7b5=1, opcode_b5=1, alu_op=01) → appear in EX on consecutive cycles, no stall.
- RAW: add x1,… then add x7,x1,x2 → stall_ifid=1 for 3 cycles with ex_valid=0; the dependent instruction enters EX on cycle 4. With STALL_CNT_EN, stall_cnt=3.
- x0 destination: addi x0,x0,1 followed by a reader of x0 → no stall.
- Flush during stall: ex_flush=1 on the 2nd stall cycle → stall_ifid=0 that cycle, EX holds a bubble, and the scoreboard continues to drain.
- Hold: pipe_hold=1 for 4 cycles mid-hazard → ex_* and scoreboard frozen, stall_ifid=1; after release the remaining bubble count is unchanged.
